// File: rtl/axil_slave_write.sv
// -----------------------------------------------------------------------------
// axil_slave_write
//
// AXI-lite write slave. Holds one write address and one write data beat in
// independent single-entry registers, pairs the oldest of each, range-checks
// the address and issues one word write on a valid/ready storage port. One B
// response is returned per pair.
//
// Handshake rule for every channel here (AW, W, B, WR): a transfer happens on
// the rising clock edge where valid && ready are both high; a source holds its
// payload stable while valid is high and ready is low.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET     clock, asynchronous active-high reset
//   S_AXI_AW*                    write address channel (AWPROT ignored)
//   S_AXI_W*                     write data channel
//   S_AXI_B*                     write response channel
//   WR_VALID/READY/ADDR/DATA/STRB  word write request to storage
//   WR_ERR                       storage error, sampled on WR handshake
// -----------------------------------------------------------------------------
module axil_slave_write #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 6,
    parameter int ADDR_LIMIT       = 2**C_AXI_ADDR_WIDTH
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,

    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,

    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,

    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    output logic [1:0]                        S_AXI_BRESP,

    output logic                              WR_VALID,
    input  logic                              WR_READY,
    output logic [C_AXI_ADDR_WIDTH-$clog2(C_AXI_DATA_WIDTH/8)-1:0] WR_ADDR,
    output logic [C_AXI_DATA_WIDTH-1:0]       WR_DATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0]     WR_STRB,
    input  logic                              WR_ERR
);

    localparam int AW  = C_AXI_ADDR_WIDTH;
    localparam int DW  = C_AXI_DATA_WIDTH;
    localparam int SW  = DW / 8;
    localparam int LSB = $clog2(SW);

    // Limit is compared in AW+1 bits so that ADDR_LIMIT = 2**AW fits.
    localparam logic [AW:0] LIMIT = (AW+1)'(ADDR_LIMIT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic          aw_full;
    logic [AW-1:0] aw_addr;
    logic          w_full;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;

    logic          b_free;
    logic          pair;
    logic          in_range;
    logic          nz;
    logic          consume;
    logic          aw_hs;
    logic          w_hs;
    logic [1:0]    resp_next;

    assign b_free   = !S_AXI_BVALID || S_AXI_BREADY;
    assign pair     = aw_full && w_full && b_free;
    assign in_range = {1'b0, aw_addr} < LIMIT;
    assign nz       = |w_strb;

    // Out-of-range or empty-strobe pairs retire without touching storage.
    assign WR_VALID = pair && in_range && nz;
    assign consume  = pair && (WR_READY || !in_range || !nz);

    // A hold can refill in the same cycle its current entry is consumed.
    assign S_AXI_AWREADY = !S_AXI_ARESET && (!aw_full || consume);
    assign S_AXI_WREADY  = !S_AXI_ARESET && (!w_full  || consume);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

    assign WR_ADDR = aw_addr[AW-1:LSB];
    assign WR_DATA = w_data;
    assign WR_STRB = w_strb;

    always_comb begin
        resp_next = RESP_OKAY;
        if (!in_range)
            resp_next = RESP_DECERR;
        else if (!nz)
            resp_next = RESP_OKAY;
        else if (WR_ERR)
            resp_next = RESP_SLVERR;
    end

    // Control state: fill flags and B channel.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else begin
            if (aw_hs)
                aw_full <= 1'b1;
            else if (consume)
                aw_full <= 1'b0;

            if (w_hs)
                w_full <= 1'b1;
            else if (consume)
                w_full <= 1'b0;

            if (consume) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= resp_next;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Payload holds: qualified by the fill flags, so no reset needed.
    always_ff @(posedge S_AXI_ACLK) begin
        if (aw_hs)
            aw_addr <= S_AXI_AWADDR;
        if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
        end
    end

    // Protection bits carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^S_AXI_AWPROT;

endmodule

// File: tb/tb_axil_slave_write.sv
// -----------------------------------------------------------------------------
// tb_axil_slave_write
//
// Bench for axil_slave_write with ADDR_LIMIT = 0x20. Drivers push AW/W beats;
// a negedge monitor records accepted beats into a behavioural model that pairs
// them in arrival order and queues the expected storage writes and B codes.
// The storage side flags an error for any word whose low nibble is 0xA.
// -----------------------------------------------------------------------------
module tb_axil_slave_write;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          awvalid = 1'b0;
    logic          awready;
    logic [AW-1:0] awaddr  = '0;
    logic          wvalid  = 1'b0;
    logic          wready;
    logic [DW-1:0] wdata   = '0;
    logic [SW-1:0] wstrb   = '0;
    logic          bvalid;
    logic          bready  = 1'b1;
    logic [1:0]    bresp;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          wr_err;

    assign wr_err = (wr_data[3:0] == 4'hA);

    axil_slave_write #(
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW),
        .ADDR_LIMIT(LIMIT)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_AWADDR(awaddr),
        .S_AXI_AWPROT(3'b000),
        .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_WDATA(wdata),
        .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_BRESP(bresp),
        .WR_VALID(wr_valid),
        .WR_READY(wr_ready),
        .WR_ADDR(wr_addr),
        .WR_DATA(wr_data),
        .WR_STRB(wr_strb),
        .WR_ERR(wr_err)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;

    logic [AW-1:0]    m_aw_q[$];
    logic [SW+DW-1:0] m_w_q[$];
    logic [39:0]      exp_wr_q[$];
    logic [1:0]       exp_b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s act=%0h exp=none", name, act);
    endtask

    // Reference model: pair oldest AW with oldest W and decide the outcome.
    task automatic model_pair();
        logic [AW-1:0] a;
        logic [SW+DW-1:0] sw;
        logic [SW-1:0] s;
        logic [DW-1:0] d;
        while (m_aw_q.size() > 0 && m_w_q.size() > 0) begin
            a  = m_aw_q.pop_front();
            sw = m_w_q.pop_front();
            s  = sw[SW+DW-1:DW];
            d  = sw[DW-1:0];
            if (int'(a) >= LIMIT)
                exp_b_q.push_back(2'b11);
            else if (s == '0)
                exp_b_q.push_back(2'b00);
            else begin
                exp_wr_q.push_back({4'(int'(a) / 4), d, s});
                exp_b_q.push_back((d % 16 == 10) ? 2'b10 : 2'b00);
            end
        end
    endtask

    logic       prev_bstall = 1'b0;
    logic [1:0] prev_bresp  = 2'b00;

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid && awready) m_aw_q.push_back(awaddr);
            if (wvalid && wready)   m_w_q.push_back({wstrb, wdata});
            model_pair();
            if (wr_valid && wr_ready) begin
                if (exp_wr_q.size() == 0) fail_unexpected("wr_unexpected", 64'({wr_addr, wr_data, wr_strb}));
                else check("wr_beat", 64'({wr_addr, wr_data, wr_strb}), 64'(exp_wr_q.pop_front()));
            end
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) fail_unexpected("b_unexpected", 64'(bresp));
                else check("b_resp", 64'(bresp), 64'(exp_b_q.pop_front()));
            end
            if (prev_bstall) check("b_hold", 64'({bvalid, bresp}), 64'({1'b1, prev_bresp}));
            if (bvalid && !bready) check("wr_valid_in_b_stall", 64'(wr_valid), 64'(0));
            prev_bstall = bvalid && !bready;
            prev_bresp  = bresp;
        end else begin
            prev_bstall = 1'b0;
        end
    end

    // drivers (entered and left at posedge+1)
    task automatic send_aw(input logic [AW-1:0] a);
        logic hs;
        int n = 0;
        awvalid = 1'b1;
        awaddr  = a;
        forever begin
            @(negedge clk);
            hs = awready;
            n++;
            @(posedge clk);
            #1;
            if (hs) break;
            if (n > 500) begin
                fail_unexpected("aw_timeout", 64'(a));
                break;
            end
        end
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic hs;
        int n = 0;
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        forever begin
            @(negedge clk);
            hs = wready;
            n++;
            @(posedge clk);
            #1;
            if (hs) break;
            if (n > 500) begin
                fail_unexpected("w_timeout", 64'(d));
                break;
            end
        end
        wvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic f_aw, f_w;
    int   cnt;

    initial begin
        // reset values
        @(negedge clk);
        check("rst_awready", 64'(awready), 64'(0));
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_bvalid_bresp", 64'({bvalid, bresp}), 64'(0));
        check("rst_wr_valid", 64'(wr_valid), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_readies", 64'({awready, wready}), 64'(2'b11));
        @(posedge clk);
        #1;

        // same-cycle AW/W: latency N+1 write, N+2 response
        wr_ready = 1'b1;
        bready   = 1'b1;
        fork
            send_aw(6'h08);
            send_w(32'hDEADBEEF, 4'hF);
        join
        @(negedge clk);
        check("lat_wr", 64'({wr_valid, wr_addr, wr_data}), 64'({1'b1, 4'd2, 32'hDEADBEEF}));
        @(negedge clk);
        check("lat_b", 64'({bvalid, bresp}), 64'({1'b1, 2'b00}));
        idle(2);

        // W three cycles ahead of AW
        send_w(32'h0000_1111, 4'hF);
        @(negedge clk);
        check("w_first_wready_low", 64'(wready), 64'(0));
        idle(2);
        send_aw(6'h04);
        idle(4);

        // out of range, empty strobe, storage error
        fork send_aw(6'h24); send_w(32'h5555_0000, 4'hF); join
        idle(3);
        fork send_aw(6'h10); send_w(32'h6666_0000, 4'h0); join
        idle(3);
        fork send_aw(6'h14); send_w(32'h1234_567A, 4'h3); join
        idle(3);

        // B back-pressure with three queued pairs
        bready = 1'b0;
        f_aw = 1'b0;
        f_w  = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send_aw(6'(4 * i + 8));
                f_aw = 1'b1;
            end
            begin
                for (int i = 0; i < 3; i++) send_w(32'hA0B0_0000 + 32'(i), 4'hF);
                f_w = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        check("bp_stalled", 64'({bvalid, wr_valid, awready, wready}), 64'(4'b1000));
        @(posedge clk);
        #1 bready = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bvalid && bready) cnt++;
        end
        check("bp_drain_rate", 64'(cnt), 64'(3));
        cnt = 0;
        while (!(f_aw && f_w) && cnt < 100) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        idle(3);

        // reset while a write is pending
        wr_ready = 1'b0;
        fork send_aw(6'h0C); send_w(32'h7777_0001, 4'hF); join
        @(negedge clk);
        check("pre_rst_wr_valid", 64'(wr_valid), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("async_rst_outputs", 64'({awready, wready, bvalid, bresp, wr_valid}), 64'(0));
        m_aw_q.delete();
        m_w_q.delete();
        exp_wr_q.delete();
        exp_b_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        wr_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bvalid || wr_valid) cnt++;
        end
        check("no_b_after_rst", 64'(cnt), 64'(0));
        @(posedge clk);
        #1;

        // randomized traffic with random back-pressure
        f_aw = 1'b0;
        f_w  = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 2));
                    send_aw(6'($urandom_range(0, 63)));
                end
                f_aw = 1'b1;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 2));
                    send_w($urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
                end
                f_w = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !(f_aw && f_w); n++) begin
                    @(posedge clk);
                    #1;
                    wr_ready = 1'($urandom_range(0, 1));
                    bready   = 1'($urandom_range(0, 1));
                end
            end
        join
        wr_ready = 1'b1;
        bready   = 1'b1;
        cnt = 0;
        while ((exp_wr_q.size() != 0 || exp_b_q.size() != 0) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_outstanding", 64'(exp_wr_q.size() + exp_b_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
